// File: rtl/inst_encoder.sv
`timescale 1ns/1ps
// inst_encoder: program loader that packs decoded RV32I field tuples into
//   32-bit instruction words and streams them into imem at sequential addresses.
// Latency: a tuple accepted at edge N drives mem_we/mem_addr/mem_wdata from edge N.
// Backpressure: one-entry output stage; in_ready drops while a word waits on mem_ready.
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   start               one-cycle pulse, begins/restarts a load session
//   in_valid/in_ready   tuple handshake; op/rd/rs1/rs2/funct3/funct7/imm/last fields
//   mem_we/mem_addr/mem_wdata/mem_ready   imem write port
//   busy/done/err/err_code/count          session status
module inst_encoder #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        op,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  input  logic              last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   count
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [ADDR_W-1:0] LP_BASE  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   LP_DEPTH = (ADDR_W+1)'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE, S_ERROR} state_t;

  state_t            r_state, w_next;
  logic              r_we;
  logic [ADDR_W-1:0] r_ptr;
  logic [31:0]       r_wdata;
  logic [ADDR_W:0]   r_count;
  logic [ADDR_W:0]   r_acc;     // words accepted this session (overflow guard)
  logic              r_done, r_err;
  logic [1:0]        r_code;

  logic [31:0] w_enc;
  logic        w_bad_op, w_bad_imm, w_ovf, w_tup_err;
  logic [1:0]  w_code;
  logic        w_wr_done, w_acc;
  logic        w_sx12, w_sx13, w_sx21;

  // Immediate fits when all bits above the field's sign bit match it.
  assign w_sx12 = (&imm[31:11]) | ~(|imm[31:11]);
  assign w_sx13 = (&imm[31:12]) | ~(|imm[31:12]);
  assign w_sx21 = (&imm[31:20]) | ~(|imm[31:20]);

  always_comb begin
    w_enc     = '0;
    w_bad_op  = 1'b0;
    w_bad_imm = 1'b0;
    case (op)
      OP_R: w_enc = {funct7, rs2, rs1, funct3, rd, op};
      OP_LOAD, OP_JALR: begin
        w_enc     = {imm[11:0], rs1, funct3, rd, op};
        w_bad_imm = !w_sx12;
      end
      OP_IMM: begin
        // Shift-immediates carry funct7 in the top bits and a 5-bit shamt.
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          w_enc     = {funct7, imm[4:0], rs1, funct3, rd, op};
          w_bad_imm = |imm[31:5];
        end else begin
          w_enc     = {imm[11:0], rs1, funct3, rd, op};
          w_bad_imm = !w_sx12;
        end
      end
      OP_STORE: begin
        w_enc     = {imm[11:5], rs2, rs1, funct3, imm[4:0], op};
        w_bad_imm = !w_sx12;
      end
      OP_BR: begin
        w_enc     = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op};
        w_bad_imm = !w_sx13 || imm[0];
      end
      OP_LUI, OP_AUIPC: begin
        w_enc     = {imm[31:12], rd, op};
        w_bad_imm = |imm[11:0];
      end
      OP_JAL: begin
        w_enc     = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
        w_bad_imm = !w_sx21 || imm[0];
      end
      default: w_bad_op = 1'b1;
    endcase
  end

  assign w_ovf     = (r_acc == LP_DEPTH);
  assign w_tup_err = w_ovf | w_bad_op | w_bad_imm;
  assign w_code    = w_ovf ? 2'b11 : (w_bad_op ? 2'b10 : (w_bad_imm ? 2'b01 : 2'b00));

  // start wins over a same-cycle tuple, so it also blocks acceptance.
  assign in_ready  = (r_state == S_LOAD) && (!r_we || mem_ready) && !start;
  assign w_acc     = in_valid && in_ready;
  assign w_wr_done = r_we && mem_ready;

  always_comb begin
    w_next = r_state;
    if (start) begin
      w_next = S_LOAD;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_acc && w_tup_err)  w_next = S_ERROR;
          else if (w_acc && last)  w_next = S_DRAIN;
        end
        S_DRAIN: if (w_wr_done)    w_next = S_DONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_ptr   <= LP_BASE;
      r_wdata <= '0;
      r_count <= '0;
      r_acc   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_code  <= 2'b00;
    end else if (start) begin
      // Discard any pending word; the session restarts from the base address.
      r_we    <= 1'b0;
      r_ptr   <= LP_BASE;
      r_count <= '0;
      r_acc   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_code  <= 2'b00;
    end else begin
      if (w_wr_done) begin
        r_ptr   <= r_ptr + ADDR_W'(1);
        r_count <= r_count + (ADDR_W+1)'(1);
      end
      if (w_acc && !w_tup_err) begin
        r_we    <= 1'b1;
        r_wdata <= w_enc;
        r_acc   <= r_acc + (ADDR_W+1)'(1);
      end else if (w_wr_done) begin
        r_we    <= 1'b0;
      end
      // A rejected tuple leaves the output stage alone so its write still completes.
      if (w_acc && w_tup_err) begin
        r_err  <= 1'b1;
        r_code <= w_code;
      end
      if (r_state == S_DRAIN && w_wr_done) r_done <= 1'b1;
    end
  end

  assign mem_we    = r_we;
  assign mem_addr  = r_ptr;
  assign mem_wdata = r_wdata;
  assign busy      = (r_state == S_LOAD) || (r_state == S_DRAIN);
  assign done      = r_done;
  assign err       = r_err;
  assign err_code  = r_code;
  assign count     = r_count;

endmodule

// File: tb/tb_inst_encoder.sv
`timescale 1ns/1ps
// tb_inst_encoder: directed and randomized load sessions against a
//   behavioural encoder/session model; writes captured from the imem port.
module tb_inst_encoder;
  localparam int AW = 4, BASE = 2, DEP = 4;

  logic clk = 0, rst = 1, start = 0, in_valid = 0, last = 0, mem_ready = 1;
  logic in_ready, mem_we, busy, done, err;
  logic [6:0] op = 0, funct7 = 0;
  logic [4:0] rd = 0, rs1 = 0, rs2 = 0;
  logic [2:0] funct3 = 0;
  logic [31:0] imm = 0, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [1:0] err_code;
  logic [AW:0] count;

  inst_encoder #(.ADDR_W(AW), .BASE_ADDR(BASE), .DEPTH(DEP)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
    .imm(imm), .last(last), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .busy(busy), .done(done),
    .err(err), .err_code(err_code), .count(count));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] op, rd, rs1, rs2, f3, f7, imm;
    bit last;
  } tup_t;

  tup_t tq[$];
  logic [31:0] exp_a[$], exp_d[$], got_a[$], got_d[$];
  int got_c[$];
  int cyc = 0;
  int n_cmp = 0, n_bad = 0;
  int exp_fin, exp_cnt, n_offer;
  logic [1:0] exp_code;
  int rdy_mode = 0;   // 0: ready high, 1: random, 2: driven by the test

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // A write completes at the next edge when mem_we && mem_ready are stable here.
  always @(negedge clk)
    if (!rst && mem_we && mem_ready) begin
      got_a.push_back(32'(mem_addr));
      got_d.push_back(mem_wdata);
      got_c.push_back(cyc);
    end

  initial forever begin
    @(posedge clk); #1;
    if (rdy_mode == 0) mem_ready = 1;
    else if (rdy_mode == 1) mem_ready = ($urandom_range(0, 3) != 0);
  end

  function automatic tup_t mk(input int o, d, s1, s2, f3, f7, input logic [31:0] im, input bit l);
    tup_t t;
    t.op = o; t.rd = d; t.rs1 = s1; t.rs2 = s2; t.f3 = f3; t.f7 = f7; t.imm = im; t.last = l;
    return t;
  endfunction

  // Reference encoder: legality by numeric range, fields placed by shift/mask.
  function automatic logic [31:0] ref_enc(input tup_t t, output logic [1:0] code);
    int si;
    logic [31:0] w;
    si = t.imm;
    code = 2'b00;
    w = 0;
    case (t.op)
      32'h33: w = (t.f7 << 25) | (t.rs2 << 20) | (t.rs1 << 15) | (t.f3 << 12) | (t.rd << 7) | t.op;
      32'h03, 32'h67, 32'h13: begin
        if (t.op == 32'h13 && (t.f3 == 1 || t.f3 == 5)) begin
          if (t.imm > 31) code = 2'b01;
          w = (t.f7 << 25) | ((t.imm & 31) << 20) | (t.rs1 << 15) | (t.f3 << 12) | (t.rd << 7) | t.op;
        end else begin
          if (si < -2048 || si > 2047) code = 2'b01;
          w = ((t.imm & 32'hFFF) << 20) | (t.rs1 << 15) | (t.f3 << 12) | (t.rd << 7) | t.op;
        end
      end
      32'h23: begin
        if (si < -2048 || si > 2047) code = 2'b01;
        w = (((t.imm >> 5) & 127) << 25) | (t.rs2 << 20) | (t.rs1 << 15) | (t.f3 << 12)
          | ((t.imm & 31) << 7) | t.op;
      end
      32'h63: begin
        if (si < -4096 || si > 4095 || (si % 2) != 0) code = 2'b01;
        w = (((t.imm >> 12) & 1) << 31) | (((t.imm >> 5) & 63) << 25) | (t.rs2 << 20)
          | (t.rs1 << 15) | (t.f3 << 12) | (((t.imm >> 1) & 15) << 8)
          | (((t.imm >> 11) & 1) << 7) | t.op;
      end
      32'h37, 32'h17: begin
        if ((t.imm % 4096) != 0) code = 2'b01;
        w = (t.imm & 32'hFFFFF000) | (t.rd << 7) | t.op;
      end
      32'h6F: begin
        if (si < -1048576 || si > 1048575 || (si % 2) != 0) code = 2'b01;
        w = (((t.imm >> 20) & 1) << 31) | (((t.imm >> 1) & 1023) << 21)
          | (((t.imm >> 11) & 1) << 20) | (((t.imm >> 12) & 255) << 12) | (t.rd << 7) | t.op;
      end
      default: code = 2'b10;
    endcase
    return w;
  endfunction

  // Session model: which tuples get offered, what gets written, final status.
  task automatic model_session();
    logic [1:0] c;
    logic [31:0] w;
    exp_a.delete(); exp_d.delete();
    exp_fin = 0; exp_code = 0; n_offer = 0;
    for (int i = 0; i < tq.size(); i++) begin
      n_offer++;
      if (exp_a.size() == DEP) begin exp_code = 2'b11; exp_fin = 2; break; end
      w = ref_enc(tq[i], c);
      if (c != 0) begin exp_code = c; exp_fin = 2; break; end
      exp_a.push_back(BASE + exp_a.size());
      exp_d.push_back(w);
      if (tq[i].last) begin exp_fin = 1; break; end
    end
    exp_cnt = exp_a.size();
  endtask

  task automatic drive(input tup_t t);
    op = t.op[6:0]; rd = t.rd[4:0]; rs1 = t.rs1[4:0]; rs2 = t.rs2[4:0];
    funct3 = t.f3[2:0]; funct7 = t.f7[6:0]; imm = t.imm; last = t.last;
  endtask

  task automatic offer(input tup_t t);
    bit ok = 0;
    drive(t);
    in_valid = 1;
    for (int k = 0; k < 64 && !ok; k++) begin
      @(negedge clk); ok = in_ready;
      @(posedge clk); #1;
    end
    if (!ok) check("accept_timeout", 0, 1);
  endtask

  task automatic offer_all();
    for (int i = 0; i < n_offer; i++) offer(tq[i]);
    in_valid = 0;
  endtask

  task automatic pulse_start();
    got_a.delete(); got_d.delete(); got_c.delete();
    start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic finish_check(input string tag);
    bit ok = 0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk); ok = !mem_we && (exp_fin == 0 || !busy);
    end
    if (!ok) check({tag, "_drain_timeout"}, 0, 1);
    check({tag, "_count"}, count, exp_cnt);
    check({tag, "_done"}, done, exp_fin == 1);
    check({tag, "_err"}, err, exp_fin == 2);
    check({tag, "_code"}, err_code, exp_code);
    check({tag, "_busy"}, busy, exp_fin == 0);
    check({tag, "_inrdy"}, in_ready, exp_fin == 0);
    check({tag, "_nwr"}, got_a.size(), exp_a.size());
    for (int i = 0; i < exp_a.size(); i++)
      if (i < got_a.size()) begin
        check({tag, "_addr"}, got_a[i], exp_a[i]);
        check({tag, "_data"}, got_d[i], exp_d[i]);
      end
    @(posedge clk); #1;
  endtask

  task automatic run_session(input string tag);
    model_session();
    pulse_start();
    offer_all();
    finish_check(tag);
  endtask

  function automatic tup_t rnd_tup();
    tup_t t;
    int k, w;
    logic [31:0] x;
    k = $urandom_range(0, 10);
    t = mk(0, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
           $urandom_range(0, 7), $urandom_range(0, 127), 0, 0);
    case (k)
      0: t.op = 32'h33;  1: t.op = 32'h03;  2: t.op = 32'h67;  3: t.op = 32'h13;
      4: begin t.op = 32'h13; t.f3 = ($urandom_range(0, 1) != 0) ? 1 : 5; end
      5: t.op = 32'h23;  6: t.op = 32'h63;  7: t.op = 32'h37;  8: t.op = 32'h17;
      9: t.op = 32'h6F;
      default: t.op = $urandom_range(0, 127);
    endcase
    w = $urandom_range(1, 22);
    x = $urandom;
    t.imm = $signed(x << (32 - w)) >>> (32 - w);
    if ($urandom_range(0, 7) == 0) t.imm = $urandom;
    if ((k == 6 || k == 9) && $urandom_range(0, 3) != 0) t.imm = t.imm & 32'hFFFFFFFE;
    if ((k == 7 || k == 8) && $urandom_range(0, 3) != 0) t.imm = t.imm & 32'hFFFFF000;
    if (k == 4 && $urandom_range(0, 3) != 0) t.imm = $urandom_range(0, 31);
    return t;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    @(negedge clk);
    check("rst_we", mem_we, 0);  check("rst_busy", busy, 0);
    check("rst_done", done, 0);  check("rst_err", err, 0);
    check("rst_code", err_code, 0); check("rst_count", count, 0);
    check("rst_wdata", mem_wdata, 0); check("rst_inrdy", in_ready, 0);
    @(posedge clk); #1; rst = 0;

    // Tuples are ignored in IDLE
    drive(mk(32'h13, 1, 2, 0, 0, 0, 32'hFFFFFFFF, 0));
    in_valid = 1;
    @(negedge clk); check("idle_inrdy", in_ready, 0);
    @(posedge clk); #1; in_valid = 0;

    // Basic stream
    tq.delete();
    tq.push_back(mk(32'h13, 1, 2, 0, 0, 0, 32'hFFFFFFFF, 0));
    tq.push_back(mk(32'h33, 3, 1, 2, 0, 0, 0, 0));
    tq.push_back(mk(32'h23, 0, 1, 2, 2, 0, 8, 1));
    run_session("basic");
    check("basic_addi", got_d[0], 32'hFFF10093);
    check("basic_add", got_d[1], 32'h002081B3);
    check("basic_sw", got_d[2], 32'h0020A423);
    check("basic_a0", got_a[0], BASE);
    check("basic_tput", got_c[2] - got_c[0], 2);

    // Branch / jump / upper immediates
    tq.delete();
    tq.push_back(mk(32'h63, 0, 1, 2, 0, 0, 32'hFFFFFFFC, 0));
    tq.push_back(mk(32'h6F, 1, 0, 0, 0, 0, 2048, 0));
    tq.push_back(mk(32'h37, 5, 0, 0, 0, 0, 32'h12345000, 1));
    run_session("bju");
    check("bju_beq", got_d[0], 32'hFE208EE3);
    check("bju_jal", got_d[1], 32'h001000EF);
    check("bju_lui", got_d[2], 32'h123452B7);

    // Backpressure: first word held for three cycles
    tq.delete();
    tq.push_back(mk(32'h13, 1, 2, 0, 0, 0, 5, 0));
    tq.push_back(mk(32'h33, 3, 1, 2, 0, 0, 0, 1));
    model_session();
    rdy_mode = 2; mem_ready = 0;
    pulse_start();
    offer(tq[0]);
    drive(tq[1]); in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_we", mem_we, 1);
      check("bp_addr", mem_addr, BASE);
      check("bp_wdata", mem_wdata, exp_d[0]);
      check("bp_inrdy", in_ready, 0);
      @(posedge clk); #1;
    end
    mem_ready = 1; rdy_mode = 0;
    offer(tq[1]); in_valid = 0;
    finish_check("bp");

    // Validation errors
    tq.delete(); tq.push_back(mk(32'h13, 1, 2, 0, 0, 0, 32'h800, 1));
    run_session("err_imm");
    tq.delete(); tq.push_back(mk(32'h00, 1, 2, 3, 0, 0, 0, 1));
    run_session("err_op");
    tq.delete(); tq.push_back(mk(32'h63, 0, 1, 2, 0, 0, 3, 1));
    run_session("err_br");

    // Overflow: five tuples, no last
    tq.delete();
    for (int i = 0; i < 5; i++) tq.push_back(mk(32'h13, i + 1, 0, 0, 0, 0, i, 0));
    run_session("ovf");
    check("ovf_code_lit", err_code, 2'b11);

    // Abort: start with in_valid while a word is pending
    tq.delete(); tq.push_back(mk(32'h13, 1, 2, 0, 0, 0, 7, 0));
    rdy_mode = 2; mem_ready = 0;
    pulse_start();
    offer(tq[0]);
    drive(mk(32'h33, 4, 5, 6, 0, 0, 0, 0));
    in_valid = 1; start = 1;
    @(posedge clk); #1; start = 0; in_valid = 0;
    @(negedge clk);
    check("abort_we", mem_we, 0);
    check("abort_count", count, 0);
    check("abort_busy", busy, 1);
    @(posedge clk); #1;
    mem_ready = 1; rdy_mode = 0;
    got_a.delete(); got_d.delete(); got_c.delete();
    tq.delete(); tq.push_back(mk(32'h33, 7, 8, 9, 0, 32, 0, 1));
    model_session();
    offer_all();
    finish_check("abort");

    // Randomized sessions with random write backpressure
    rdy_mode = 1;
    for (int s = 0; s < 14; s++) begin
      int n;
      n = $urandom_range(1, 6);
      tq.delete();
      for (int i = 0; i < n; i++) tq.push_back(rnd_tup());
      tq[n-1].last = 1;
      run_session("rnd");
    end
    rdy_mode = 0;

    // Asynchronous reset drops a pending write immediately
    rdy_mode = 2; mem_ready = 0;
    tq.delete(); tq.push_back(mk(32'h13, 1, 2, 0, 0, 0, 9, 0));
    pulse_start();
    offer(tq[0]);
    #2 rst = 1;
    #1 check("arst_we", mem_we, 0);
    check("arst_busy", busy, 0);
    @(posedge clk); #1; rst = 0; in_valid = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
